// File: rtl/alu_sequencer_if.sv
// Request / ALU / response bundle for alu_sequencer, plus the ALU function and status-bit codes.
// slave = the sequencer's view; master = the decoder/ALU side.
`ifndef ALU_SEQ_FUNC_CODES
`define ALU_SEQ_FUNC_CODES
`define NO_OPP      3'd0
`define SUM         3'd1
`define AND         3'd2
`define OR          3'd3
`define XOR         3'd4
`define SR          3'd5
`define CARRY       0
`define V_OVERFLOW  6
`endif

interface alu_sequencer_if #(
    parameter int unsigned REG_WIDTH = 8,
    parameter int unsigned OPP_WIDTH = 3
);
    logic                 req_valid;
    logic                 req_ready;
    logic [3:0]           req_op;
    logic [REG_WIDTH-1:0] req_a;
    logic [REG_WIDTH-1:0] req_b;
    logic [REG_WIDTH-1:0] req_status;

    logic [REG_WIDTH-1:0] alu_a;
    logic [REG_WIDTH-1:0] alu_b;
    logic [OPP_WIDTH-1:0] alu_func;
    logic                 alu_carry;
    logic                 alu_invert;
    logic [REG_WIDTH-1:0] alu_dout;
    logic [REG_WIDTH-1:0] alu_status;
    logic                 alu_wout;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [REG_WIDTH-1:0] rsp_result;
    logic [REG_WIDTH-1:0] rsp_status;
    logic                 rsp_wr;
    logic                 rsp_err;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_status,
        output req_ready,
        output alu_a, alu_b, alu_func, alu_carry, alu_invert,
        input  alu_dout, alu_status, alu_wout,
        output rsp_valid, rsp_result, rsp_status, rsp_wr, rsp_err,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_status,
        input  req_ready,
        input  alu_a, alu_b, alu_func, alu_carry, alu_invert,
        output alu_dout, alu_status, alu_wout,
        input  rsp_valid, rsp_result, rsp_status, rsp_wr, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/alu_sequencer.sv
// 6502 ALU micro-sequencer: request -> NO_OPP clear cycle -> issue -> flagged response.
// Define ALU_SEQ_TIMEOUT_EN to abort an ISSUE that waits TIMEOUT cycles without alu_wout.
module alu_sequencer #(
    parameter int unsigned REG_WIDTH = 8,
    parameter int unsigned OPP_WIDTH = 3,
    parameter int unsigned TIMEOUT   = 4
) (
    input  logic           phi1,
    input  logic           reset,
    alu_sequencer_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [3:0] OP_ADC = 4'd0;
    localparam logic [3:0] OP_SBC = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_ORA = 4'd3;
    localparam logic [3:0] OP_EOR = 4'd4;
    localparam logic [3:0] OP_ASL = 4'd5;
    localparam logic [3:0] OP_LSR = 4'd6;
    localparam logic [3:0] OP_ROL = 4'd7;
    localparam logic [3:0] OP_ROR = 4'd8;
    localparam logic [3:0] OP_INC = 4'd9;
    localparam logic [3:0] OP_DEC = 4'd10;
    localparam logic [3:0] OP_CMP = 4'd11;
    localparam logic [3:0] OP_BIT = 4'd12;

    localparam int unsigned N_BIT = 7;
    localparam int unsigned V_BIT = 6;
    localparam int unsigned Z_BIT = 1;
    localparam int unsigned C_BIT = 0;

    localparam logic [OPP_WIDTH-1:0] F_NOP = OPP_WIDTH'(`NO_OPP);
    localparam logic [OPP_WIDTH-1:0] F_SUM = OPP_WIDTH'(`SUM);
    localparam logic [OPP_WIDTH-1:0] F_AND = OPP_WIDTH'(`AND);
    localparam logic [OPP_WIDTH-1:0] F_OR  = OPP_WIDTH'(`OR);
    localparam logic [OPP_WIDTH-1:0] F_XOR = OPP_WIDTH'(`XOR);
    localparam logic [OPP_WIDTH-1:0] F_SR  = OPP_WIDTH'(`SR);

    logic [1:0]           state_q, state_d;
    logic [3:0]           op_q, op_d;
    logic [REG_WIDTH-1:0] a_q, a_d;
    logic [REG_WIDTH-1:0] b_q, b_d;
    logic [REG_WIDTH-1:0] st_q, st_d;

    logic                 req_ready_q, req_ready_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_wr_q, rsp_wr_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [REG_WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic [REG_WIDTH-1:0] rsp_status_q, rsp_status_d;

    logic [REG_WIDTH-1:0] alu_a_q, alu_a_d;
    logic [REG_WIDTH-1:0] alu_b_q, alu_b_d;
    logic [OPP_WIDTH-1:0] alu_func_q, alu_func_d;
    logic                 alu_carry_q, alu_carry_d;
    logic                 alu_invert_q, alu_invert_d;

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
    logic [WAIT_W-1:0] wait_q, wait_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    // Only the carry and overflow bits of the ALU status are consumed.
    logic unused_alu_status;
    assign unused_alu_status = ^bus.alu_status;

    logic [OPP_WIDTH-1:0] tbl_func;
    logic [REG_WIDTH-1:0] tbl_b;
    logic                 tbl_inv;
    logic                 tbl_cin;

    always_comb begin
        tbl_func = F_SUM;
        tbl_b    = b_q;
        tbl_inv  = 1'b0;
        tbl_cin  = 1'b0;
        case (op_q)
            OP_ADC: tbl_cin = st_q[C_BIT];
            OP_SBC: begin tbl_inv = 1'b1; tbl_cin = st_q[C_BIT]; end
            OP_CMP: begin tbl_inv = 1'b1; tbl_cin = 1'b1; end
            OP_AND, OP_BIT: tbl_func = F_AND;
            OP_ORA: tbl_func = F_OR;
            OP_EOR: tbl_func = F_XOR;
            OP_ASL: tbl_b = a_q;
            OP_ROL: begin tbl_b = a_q; tbl_cin = st_q[C_BIT]; end
            OP_LSR: begin tbl_func = F_SR; tbl_b = '0; end
            OP_ROR: begin tbl_func = F_SR; tbl_b = '0; tbl_cin = st_q[C_BIT]; end
            OP_INC: begin tbl_b = '0; tbl_cin = 1'b1; end
            OP_DEC: begin tbl_b = '0; tbl_inv = 1'b1; end
            default: tbl_func = F_NOP;
        endcase
    end

    logic [REG_WIDTH-1:0] flag_st;
    logic                 flag_c;
    logic                 flag_wr;

    // N and Z always come from the result itself; the ALU's own N/Z are ignored.
    always_comb begin
        flag_st        = st_q;
        flag_c         = bus.alu_status[`CARRY] ^ alu_invert_q;
        flag_st[N_BIT] = bus.alu_dout[REG_WIDTH-1];
        flag_st[Z_BIT] = (bus.alu_dout == '0);
        case (op_q)
            OP_ADC, OP_SBC: begin
                flag_st[C_BIT] = flag_c;
                flag_st[V_BIT] = bus.alu_status[`V_OVERFLOW];
            end
            OP_CMP, OP_ASL, OP_LSR, OP_ROL, OP_ROR: flag_st[C_BIT] = flag_c;
            OP_BIT: begin
                flag_st[N_BIT] = b_q[REG_WIDTH-1];
                flag_st[V_BIT] = b_q[REG_WIDTH-2];
            end
            default: ;
        endcase
        flag_wr = !((op_q == OP_CMP) || (op_q == OP_BIT));
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        st_d         = st_q;
        req_ready_d  = req_ready_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_wr_d     = rsp_wr_q;
        rsp_err_d    = rsp_err_q;
        rsp_result_d = rsp_result_q;
        rsp_status_d = rsp_status_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_func_d   = alu_func_q;
        alu_carry_d  = alu_carry_q;
        alu_invert_d = alu_invert_q;
`ifdef ALU_SEQ_TIMEOUT_EN
        wait_d       = wait_q;
`endif
        case (state_q)
            S_IDLE: begin
                alu_func_d = F_NOP;
                if (bus.req_valid && req_ready_q) begin
                    op_d        = bus.req_op;
                    a_d         = bus.req_a;
                    b_d         = bus.req_b;
                    st_d        = bus.req_status;
                    req_ready_d = 1'b0;
                    if (bus.req_op <= OP_BIT) begin
                        state_d = S_CLEAR;
                    end else begin
                        state_d      = S_RESP;
                        rsp_valid_d  = 1'b1;
                        rsp_err_d    = 1'b1;
                        rsp_wr_d     = 1'b0;
                        rsp_result_d = '0;
                        rsp_status_d = bus.req_status;
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            S_CLEAR: begin
                // alu_func is still NO_OPP this cycle; the op function lands with ISSUE.
                alu_a_d      = a_q;
                alu_b_d      = tbl_b;
                alu_invert_d = tbl_inv;
                alu_carry_d  = tbl_cin ^ tbl_inv;
                alu_func_d   = tbl_func;
                state_d      = S_ISSUE;
`ifdef ALU_SEQ_TIMEOUT_EN
                wait_d       = '0;
`endif
            end
            S_ISSUE: begin
                if (bus.alu_wout) begin
                    state_d      = S_RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_err_d    = 1'b0;
                    rsp_wr_d     = flag_wr;
                    rsp_result_d = bus.alu_dout;
                    rsp_status_d = flag_st;
                    alu_func_d   = F_NOP;
                end
`ifdef ALU_SEQ_TIMEOUT_EN
                else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    state_d      = S_RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_err_d    = 1'b1;
                    rsp_wr_d     = 1'b0;
                    rsp_result_d = '0;
                    rsp_status_d = st_q;
                    alu_func_d   = F_NOP;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
`endif
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge phi1) begin
        if (reset) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            st_q         <= '0;
            req_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_wr_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_result_q <= '0;
            rsp_status_q <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_func_q   <= F_NOP;
            alu_carry_q  <= 1'b0;
            alu_invert_q <= 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
            wait_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            st_q         <= st_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_wr_q     <= rsp_wr_d;
            rsp_err_q    <= rsp_err_d;
            rsp_result_q <= rsp_result_d;
            rsp_status_q <= rsp_status_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_func_q   <= alu_func_d;
            alu_carry_q  <= alu_carry_d;
            alu_invert_q <= alu_invert_d;
`ifdef ALU_SEQ_TIMEOUT_EN
            wait_q       <= wait_d;
`endif
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_wr     = rsp_wr_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_status = rsp_status_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_func   = alu_func_q;
    assign bus.alu_carry  = alu_carry_q;
    assign bus.alu_invert = alu_invert_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a registered one-cycle behavioural ALU.
`ifndef ALU_SEQ_FUNC_CODES
`define ALU_SEQ_FUNC_CODES
`define NO_OPP      3'd0
`define SUM         3'd1
`define AND         3'd2
`define OR          3'd3
`define XOR         3'd4
`define SR          3'd5
`define CARRY       0
`define V_OVERFLOW  6
`endif

module tb_alu_sequencer;
    logic phi1  = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    logic alu_dead = 1'b0;
    int   func_busy = 0;

    alu_sequencer_if #(.REG_WIDTH(8), .OPP_WIDTH(3)) bus ();

    alu_sequencer #(.REG_WIDTH(8), .OPP_WIDTH(3), .TIMEOUT(4)) dut (
        .phi1  (phi1),
        .reset (reset),
        .bus   (bus)
    );

    always #5 phi1 = ~phi1;

    // ALU model: invert selects A + ~B; it adds 1 when carry_in != invert; in
    // invert mode its carry output is a borrow.
    logic [7:0] m_be, m_r;
    logic [8:0] m_sum;
    logic       m_inc, m_c, m_v;
    always @(posedge phi1) begin
        if (reset) begin
            bus.alu_wout   <= 1'b0;
            bus.alu_dout   <= 8'h00;
            bus.alu_status <= 8'h00;
        end else begin
            m_be  = bus.alu_invert ? ~bus.alu_b : bus.alu_b;
            m_inc = bus.alu_carry ^ bus.alu_invert;
            m_sum = {1'b0, bus.alu_a} + {1'b0, m_be} + {8'd0, m_inc};
            m_r   = m_sum[7:0];
            m_c   = m_sum[8];
            m_v   = (bus.alu_a[7] == m_be[7]) && (m_sum[7] != bus.alu_a[7]);
            case (bus.alu_func)
                `AND: begin m_r = bus.alu_a & bus.alu_b; m_c = 1'b0; m_v = 1'b0; end
                `OR:  begin m_r = bus.alu_a | bus.alu_b; m_c = 1'b0; m_v = 1'b0; end
                `XOR: begin m_r = bus.alu_a ^ bus.alu_b; m_c = 1'b0; m_v = 1'b0; end
                `SR:  begin m_r = {m_inc, bus.alu_a[7:1]}; m_c = bus.alu_a[0]; m_v = 1'b0; end
                default: ;
            endcase
            bus.alu_dout   <= m_r;
            bus.alu_status <= {1'b1, m_v, 5'b11111, m_c ^ bus.alu_invert};
            bus.alu_wout   <= (bus.alu_func != `NO_OPP) && !alu_dead;
        end
    end

    always @(posedge phi1) if (bus.alu_func != `NO_OPP) func_busy++;

    task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] st, output logic [7:0] r, output logic [7:0] s,
                         output logic wr, output logic err, output int lat);
        int n;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin @(posedge phi1); #1; n++; end
        bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_status = st;
        bus.req_valid = 1'b1;
        @(posedge phi1); #1;
        bus.req_valid = 1'b0;
        lat = 0;
        while (bus.rsp_valid !== 1'b1 && lat < 30) begin @(posedge phi1); #1; lat++; end
        r = bus.rsp_result; s = bus.rsp_status; wr = bus.rsp_wr; err = bus.rsp_err;
        bus.rsp_ready = 1'b1;
        @(posedge phi1); #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge phi1);
        #1;
        n_vec++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_wr, bus.rsp_err} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ctrl got %b exp 0000",
                     {bus.req_ready, bus.rsp_valid, bus.rsp_wr, bus.rsp_err});
        end
        n_vec++;
        if ({bus.alu_carry, bus.alu_invert, bus.alu_func} !== {2'b00, `NO_OPP}) begin
            n_err++;
            $display("FAIL reset_alu_ctrl got %b exp 00000",
                     {bus.alu_carry, bus.alu_invert, bus.alu_func});
        end
        n_vec++;
        if ({bus.rsp_result, bus.rsp_status, bus.alu_a, bus.alu_b} !== 32'h0) begin
            n_err++;
            $display("FAIL reset_data got %h exp 00000000",
                     {bus.rsp_result, bus.rsp_status, bus.alu_a, bus.alu_b});
        end
        reset = 1'b0;
        @(posedge phi1); #1;
        n_vec++;
        if (bus.req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_ready got %b exp 1", bus.req_ready);
        end
    endtask

    typedef struct {
        logic [3:0] op;
        logic [7:0] a, b, st, res, sts;
        logic       wr;
    } vec_t;

    task automatic test_ops();
        vec_t tbl [15];
        logic [7:0] r, s;
        logic wr, err;
        int lat;
        tbl[0]  = '{4'd0,  8'h50, 8'h50, 8'h2C, 8'hA0, 8'hEC, 1'b1}; // ADC overflow
        tbl[1]  = '{4'd1,  8'h00, 8'h01, 8'h21, 8'hFF, 8'hA0, 1'b1}; // SBC borrow
        tbl[2]  = '{4'd10, 8'h01, 8'h77, 8'h61, 8'h00, 8'h63, 1'b1}; // DEC to zero
        tbl[3]  = '{4'd11, 8'h40, 8'h40, 8'hC0, 8'h00, 8'h43, 1'b0}; // CMP equal
        tbl[4]  = '{4'd12, 8'h3F, 8'hC0, 8'h01, 8'h00, 8'hC3, 1'b0}; // BIT
        tbl[5]  = '{4'd8,  8'h01, 8'h55, 8'h01, 8'h80, 8'h81, 1'b1}; // ROR
        tbl[6]  = '{4'd5,  8'h80, 8'h12, 8'h40, 8'h00, 8'h43, 1'b1}; // ASL
        tbl[7]  = '{4'd6,  8'h03, 8'h00, 8'h80, 8'h01, 8'h01, 1'b1}; // LSR
        tbl[8]  = '{4'd7,  8'h80, 8'h00, 8'h01, 8'h01, 8'h01, 1'b1}; // ROL
        tbl[9]  = '{4'd9,  8'hFF, 8'h00, 8'h00, 8'h00, 8'h02, 1'b1}; // INC wrap
        tbl[10] = '{4'd4,  8'hFF, 8'h0F, 8'h00, 8'hF0, 8'h80, 1'b1}; // EOR
        tbl[11] = '{4'd3,  8'h00, 8'h00, 8'h80, 8'h00, 8'h02, 1'b1}; // ORA zero
        tbl[12] = '{4'd2,  8'hF0, 8'h3C, 8'h03, 8'h30, 8'h01, 1'b1}; // AND
        tbl[13] = '{4'd0,  8'hFF, 8'h01, 8'h43, 8'h01, 8'h01, 1'b1}; // ADC carry out
        tbl[14] = '{4'd1,  8'h80, 8'h01, 8'h01, 8'h7F, 8'h41, 1'b1}; // SBC overflow
        for (int i = 0; i < 15; i++) begin
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].st, r, s, wr, err, lat);
            n_vec++;
            if (r !== tbl[i].res) begin
                n_err++;
                $display("FAIL op%0d_result (req_op %0d) got %h exp %h", i, tbl[i].op, r, tbl[i].res);
            end
            n_vec++;
            if (s !== tbl[i].sts) begin
                n_err++;
                $display("FAIL op%0d_status (req_op %0d) got %h exp %h", i, tbl[i].op, s, tbl[i].sts);
            end
            n_vec++;
            if ({wr, err} !== {tbl[i].wr, 1'b0}) begin
                n_err++;
                $display("FAIL op%0d_wr_err got %b exp %b", i, {wr, err}, {tbl[i].wr, 1'b0});
            end
            n_vec++;
            if (lat !== 3) begin
                n_err++;
                $display("FAIL op%0d_latency got %0d exp 3", i, lat);
            end
        end
    endtask

    task automatic test_illegal();
        logic [7:0] r, s;
        logic wr, err;
        int lat;
        for (int k = 13; k < 16; k++) begin
            func_busy = 0;
            do_op(4'(k), 8'hAA, 8'h55, 8'h5A, r, s, wr, err, lat);
            n_vec++;
            if ({err, wr, r, s} !== {1'b1, 1'b0, 8'h00, 8'h5A}) begin
                n_err++;
                $display("FAIL illegal%0d_rsp got err=%b wr=%b r=%h s=%h exp 1 0 00 5a", k, err, wr, r, s);
            end
            n_vec++;
            if (lat !== 0) begin
                n_err++;
                $display("FAIL illegal%0d_latency got %0d exp 0", k, lat);
            end
            n_vec++;
            if (func_busy !== 0) begin
                n_err++;
                $display("FAIL illegal%0d_alu_idle got %0d busy cycles exp 0", k, func_busy);
            end
        end
    endtask

    task automatic test_timeout();
`ifdef ALU_SEQ_TIMEOUT_EN
        logic [7:0] r, s;
        logic wr, err;
        int lat;
        alu_dead = 1'b1;
        do_op(4'd0, 8'h01, 8'h01, 8'h24, r, s, wr, err, lat);
        alu_dead = 1'b0;
        n_vec++;
        if ({err, wr, r, s} !== {1'b1, 1'b0, 8'h00, 8'h24}) begin
            n_err++;
            $display("FAIL timeout_rsp got err=%b wr=%b r=%h s=%h exp 1 0 00 24", err, wr, r, s);
        end
        n_vec++;
        if (lat !== 5) begin
            n_err++;
            $display("FAIL timeout_latency got %0d exp 5", lat);
        end
`else
        int n, seen;
        alu_dead = 1'b1;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin @(posedge phi1); #1; n++; end
        bus.req_op = 4'd0; bus.req_a = 8'h01; bus.req_b = 8'h01; bus.req_status = 8'h24;
        bus.req_valid = 1'b1;
        @(posedge phi1); #1;
        bus.req_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge phi1); #1;
            if (bus.rsp_valid === 1'b1) seen++;
        end
        n_vec++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL no_timeout_rsp got %0d valid cycles exp 0", seen);
        end
        n_vec++;
        if (bus.alu_func !== `SUM) begin
            n_err++;
            $display("FAIL no_timeout_issue_func got %0d exp %0d", bus.alu_func, `SUM);
        end
        reset = 1'b1;
        repeat (2) @(posedge phi1);
        #1;
        reset = 1'b0;
        alu_dead = 1'b0;
        @(posedge phi1); #1;
`endif
    endtask

    task automatic test_back_to_back();
        int n, lat;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin @(posedge phi1); #1; n++; end
        bus.req_op = 4'd0; bus.req_a = 8'h01; bus.req_b = 8'h02; bus.req_status = 8'h00;
        bus.req_valid = 1'b1;
        @(posedge phi1); #1;
        bus.req_op = 4'd3; bus.req_a = 8'h0F; bus.req_b = 8'hF0; bus.req_status = 8'h02;
        n_vec++;
        if (bus.req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_ready_after_accept got %b exp 0", bus.req_ready);
        end
        lat = 0;
        while (bus.rsp_valid !== 1'b1 && lat < 30) begin @(posedge phi1); #1; lat++; end
        n_vec++;
        if (lat !== 3) begin
            n_err++;
            $display("FAIL b2b_first_latency got %0d exp 3", lat);
        end
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if ({bus.rsp_valid, bus.req_ready, bus.rsp_result, bus.rsp_status, bus.rsp_wr} !==
                {1'b1, 1'b0, 8'h03, 8'h00, 1'b1}) begin
                n_err++;
                $display("FAIL b2b_stall%0d got v=%b rdy=%b r=%h s=%h wr=%b exp 1 0 03 00 1", i,
                         bus.rsp_valid, bus.req_ready, bus.rsp_result, bus.rsp_status, bus.rsp_wr);
            end
            @(posedge phi1); #1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge phi1); #1;
        bus.rsp_ready = 1'b0;
        n_vec++;
        if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL b2b_handshake got v/rdy %b exp 01", {bus.rsp_valid, bus.req_ready});
        end
        @(posedge phi1); #1;
        bus.req_valid = 1'b0;
        n_vec++;
        if (bus.req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_second_accept got ready %b exp 0", bus.req_ready);
        end
        lat = 0;
        while (bus.rsp_valid !== 1'b1 && lat < 30) begin @(posedge phi1); #1; lat++; end
        n_vec++;
        if ({bus.rsp_result, bus.rsp_status, bus.rsp_wr, bus.rsp_err} !== {8'hFF, 8'h80, 2'b10}) begin
            n_err++;
            $display("FAIL b2b_second_rsp got r=%h s=%h wr=%b err=%b exp ff 80 1 0",
                     bus.rsp_result, bus.rsp_status, bus.rsp_wr, bus.rsp_err);
        end
        n_vec++;
        if (lat !== 3) begin
            n_err++;
            $display("FAIL b2b_second_latency got %0d exp 3", lat);
        end
        bus.rsp_ready = 1'b1;
        @(posedge phi1); #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n, seen, lat;
        logic [7:0] r, s;
        logic wr, err;
        alu_dead = 1'b1;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin @(posedge phi1); #1; n++; end
        bus.req_op = 4'd0; bus.req_a = 8'h10; bus.req_b = 8'h20; bus.req_status = 8'h00;
        bus.req_valid = 1'b1;
        @(posedge phi1); #1;
        bus.req_valid = 1'b0;
        repeat (2) @(posedge phi1);
        #1;
        n_vec++;
        if (bus.alu_func !== `SUM) begin
            n_err++;
            $display("FAIL midreset_in_issue got func %0d exp %0d", bus.alu_func, `SUM);
        end
        reset = 1'b1;
        @(posedge phi1); #1;
        n_vec++;
        if ({bus.alu_func, bus.rsp_valid, bus.req_ready, bus.alu_a} !== {`NO_OPP, 2'b00, 8'h00}) begin
            n_err++;
            $display("FAIL midreset_state got func=%0d v=%b rdy=%b a=%h exp 0 0 0 00",
                     bus.alu_func, bus.rsp_valid, bus.req_ready, bus.alu_a);
        end
        reset = 1'b0;
        alu_dead = 1'b0;
        @(posedge phi1); #1;
        n_vec++;
        if (bus.req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_ready got %b exp 1", bus.req_ready);
        end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.rsp_valid === 1'b1 || bus.alu_func !== `NO_OPP) seen++;
            @(posedge phi1); #1;
        end
        n_vec++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL midreset_quiet got %0d active cycles exp 0", seen);
        end
        do_op(4'd9, 8'h7F, 8'h00, 8'h00, r, s, wr, err, lat);
        n_vec++;
        if ({r, s, wr, err} !== {8'h80, 8'h80, 2'b10}) begin
            n_err++;
            $display("FAIL midreset_next_op got r=%h s=%h wr=%b err=%b exp 80 80 1 0", r, s, wr, err);
        end
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_op     = 4'd0;
        bus.req_a      = 8'h00;
        bus.req_b      = 8'h00;
        bus.req_status = 8'h00;
        bus.rsp_ready  = 1'b0;
        test_reset();
        test_ops();
        test_illegal();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got running exp finished");
        $fatal(1, "watchdog");
    end
endmodule
